// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty flags
// and overflow/underflow pulses. Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] Din,
    input  logic                  WR_EN,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] Dout,
    output logic                  Valid,
    output logic                  Empty,
    output logic                  Full,
    output logic                  Almost_Empty,
    output logic                  Almost_Full,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);

    generate
        if (ADDR_WIDTH < 1 || AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH || AF_LEVEL < 0 || AE_LEVEL < 0) begin : g_bad_params
            $error("sync_fifo_flags: illegal ADDR_WIDTH/AF_LEVEL/AE_LEVEL combination");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  empty_q,  empty_d;
    logic                  full_q,   full_d;
    logic                  ae_q,     ae_d;
    logic                  af_q,     af_d;
    logic                  ovf_q,    ovf_d;
    logic                  udf_q,    udf_d;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] head_word;

    // A write into a full FIFO is accepted only when a read frees the slot at the same edge.
    assign wr_ok     = WR_EN & (~full_q | RD_EN);
    assign rd_ok     = RD_EN & ~empty_q;
    assign head_word = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_CNT);
        ae_d    = (count_d <= AE_CNT);
        af_d    = (count_d >= AF_CNT);
        ovf_d   = WR_EN & full_q & ~RD_EN;
        udf_d   = RD_EN & empty_q;
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= Din;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= (AF_CNT == '0);
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef FIFO_FWFT_EN
    logic [DATA_WIDTH-1:0] hold_q;

    // Remembers the last head word shown so Dout is stable once the FIFO drains.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_q <= '0;
        end else if (!empty_q) begin
            hold_q <= head_word;
        end
    end

    assign Dout  = empty_q ? hold_q : head_word;
    assign Valid = ~empty_q;
`else
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_ok;
            if (rd_ok) begin
                dout_q <= head_word;
            end
        end
    end

    assign Dout  = dout_q;
    assign Valid = valid_q;
`endif

    assign Empty        = empty_q;
    assign Full         = full_q;
    assign Almost_Empty = ae_q;
    assign Almost_Full  = af_q;
    assign Count        = count_q;
    assign Overflow     = ovf_q;
    assign Underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags in standard (registered read) mode, DEPTH=8.
module tb_sync_fifo_flags;

    localparam int DW = 10;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] Din = '0;
    logic          WR_EN = 1'b0;
    logic          RD_EN = 1'b0;
    logic [DW-1:0] Dout;
    logic          Valid, Empty, Full, Almost_Empty, Almost_Full, Overflow, Underflow;
    logic [AW:0]   Count;

    int n_vec = 0;
    int n_err = 0;

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut (
        .CLK(CLK), .RST(RST), .Din(Din), .WR_EN(WR_EN), .RD_EN(RD_EN),
        .Dout(Dout), .Valid(Valid), .Empty(Empty), .Full(Full),
        .Almost_Empty(Almost_Empty), .Almost_Full(Almost_Full),
        .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 CLK = ~CLK;

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #12;
        RST = 1'b1;
        repeat (3) step();
        n_vec++; if (Empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", Empty); end
        n_vec++; if (Almost_Empty !== 1'b1) begin n_err++; $display("FAIL reset_ae got=%b exp=1", Almost_Empty); end
        n_vec++; if (Full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", Full); end
        n_vec++; if (Almost_Full !== 1'b0) begin n_err++; $display("FAIL reset_af got=%b exp=0", Almost_Full); end
        n_vec++; if (Count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", Count); end
        n_vec++; if (Dout !== 10'h000) begin n_err++; $display("FAIL reset_dout got=%h exp=000", Dout); end
        n_vec++; if (Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", Valid); end
        $display("reset: Empty=%b Count=%0d", Empty, Count);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            Din = DW'(i); WR_EN = 1'b1;
            step();
            n_vec++; if (Count !== 4'(i)) begin n_err++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, Count, i); end
            n_vec++; if (Almost_Empty !== (i <= 2)) begin n_err++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, Almost_Empty, (i <= 2)); end
            n_vec++; if (Almost_Full !== (i >= 6)) begin n_err++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, Almost_Full, (i >= 6)); end
            n_vec++; if (Full !== (i == 8)) begin n_err++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, Full, (i == 8)); end
            n_vec++; if (Empty !== 1'b0) begin n_err++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, Empty); end
            $display("write %03h: Count=%0d AE=%b AF=%b Full=%b", Din, Count, Almost_Empty, Almost_Full, Full);
        end
        Din = 10'h3FF;
        step();
        n_vec++; if (Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_pulse got=%b exp=1", Overflow); end
        n_vec++; if (Count !== 4'd8) begin n_err++; $display("FAIL ovf_count got=%0d exp=8", Count); end
        $display("write 3ff while full: Overflow=%b Count=%0d", Overflow, Count);
        WR_EN = 1'b0;
        step();
        n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b exp=0", Overflow); end
    endtask

    task automatic test_drain();
        RD_EN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_vec++; if (Dout !== DW'(i + 1)) begin n_err++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, Dout, DW'(i + 1)); end
            n_vec++; if (Valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, Valid); end
            n_vec++; if (Count !== 4'(7 - i)) begin n_err++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, Count, 7 - i); end
            $display("read: Dout=%03h Valid=%b Count=%0d", Dout, Valid, Count);
        end
        n_vec++; if (Empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%b exp=1", Empty); end
        step();
        n_vec++; if (Underflow !== 1'b1) begin n_err++; $display("FAIL udf_pulse got=%b exp=1", Underflow); end
        n_vec++; if (Valid !== 1'b0) begin n_err++; $display("FAIL udf_valid got=%b exp=0", Valid); end
        n_vec++; if (Dout !== 10'h008) begin n_err++; $display("FAIL udf_dout got=%h exp=008", Dout); end
        $display("read while empty: Underflow=%b Dout=%03h", Underflow, Dout);
        RD_EN = 1'b0;
        step();
        n_vec++; if (Underflow !== 1'b0) begin n_err++; $display("FAIL udf_clear got=%b exp=0", Underflow); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp_w;
        WR_EN = 1'b1;
        for (int i = 0; i < 5; i++) begin Din = DW'(10'h010 + i); step(); end
        WR_EN = 1'b0; RD_EN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_w = DW'(10'h010 + i);
            n_vec++; if (Dout !== exp_w) begin n_err++; $display("FAIL wrap_pre[%0d] got=%h exp=%h", i, Dout, exp_w); end
        end
        RD_EN = 1'b0; WR_EN = 1'b1;
        for (int i = 0; i < 6; i++) begin Din = DW'(10'h100 + i); step(); end
        WR_EN = 1'b0;
        n_vec++; if (Count !== 4'd6) begin n_err++; $display("FAIL wrap_count got=%0d exp=6", Count); end
        RD_EN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_w = DW'(10'h100 + i);
            n_vec++; if (Dout !== exp_w || Valid !== 1'b1) begin n_err++; $display("FAIL wrap_read[%0d] got=%h/%b exp=%h/1", i, Dout, Valid, exp_w); end
            $display("wrap read: Dout=%03h", Dout);
        end
        RD_EN = 1'b0;
        step();
        n_vec++; if (Empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got=%b exp=1", Empty); end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] exp_w;
        WR_EN = 1'b1;
        for (int i = 0; i < 8; i++) begin Din = DW'(10'h200 + i); step(); end
        Din = 10'h2AA; RD_EN = 1'b1;
        step();
        n_vec++; if (Count !== 4'd8 || Full !== 1'b1) begin n_err++; $display("FAIL simfull_count got=%0d/%b exp=8/1", Count, Full); end
        n_vec++; if (Dout !== 10'h200 || Valid !== 1'b1) begin n_err++; $display("FAIL simfull_pop got=%h/%b exp=200/1", Dout, Valid); end
        n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL simfull_ovf got=%b exp=0", Overflow); end
        $display("rd+wr at full: Count=%0d Dout=%03h", Count, Dout);
        WR_EN = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_w = (i == 8) ? 10'h2AA : DW'(10'h200 + i);
            n_vec++; if (Dout !== exp_w) begin n_err++; $display("FAIL simfull_order[%0d] got=%h exp=%h", i, Dout, exp_w); end
        end
        RD_EN = 1'b0;
        step();
        n_vec++; if (Count !== 4'd0) begin n_err++; $display("FAIL sim_drained got=%0d exp=0", Count); end
        Din = 10'h123; WR_EN = 1'b1; RD_EN = 1'b1;
        step();
        n_vec++; if (Underflow !== 1'b1) begin n_err++; $display("FAIL simempty_udf got=%b exp=1", Underflow); end
        n_vec++; if (Count !== 4'd1) begin n_err++; $display("FAIL simempty_count got=%0d exp=1", Count); end
        n_vec++; if (Valid !== 1'b0) begin n_err++; $display("FAIL simempty_valid got=%b exp=0", Valid); end
        $display("rd+wr at empty: Underflow=%b Count=%0d", Underflow, Count);
        WR_EN = 1'b0;
        step();
        n_vec++; if (Dout !== 10'h123 || Valid !== 1'b1) begin n_err++; $display("FAIL simempty_read got=%h/%b exp=123/1", Dout, Valid); end
        RD_EN = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        WR_EN = 1'b1;
        for (int i = 0; i < 4; i++) begin Din = DW'(10'h0A0 + i); step(); end
        WR_EN = 1'b0;
        n_vec++; if (Count !== 4'd4) begin n_err++; $display("FAIL midrst_pre got=%0d exp=4", Count); end
        RST = 1'b0;
        #2;
        n_vec++; if (Count !== 4'd0) begin n_err++; $display("FAIL midrst_count got=%0d exp=0", Count); end
        n_vec++; if (Empty !== 1'b1 || Almost_Empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty got=%b%b exp=11", Empty, Almost_Empty); end
        n_vec++; if (Full !== 1'b0 || Almost_Full !== 1'b0) begin n_err++; $display("FAIL midrst_full got=%b%b exp=00", Full, Almost_Full); end
        n_vec++; if (Dout !== 10'h000 || Valid !== 1'b0) begin n_err++; $display("FAIL midrst_dout got=%h/%b exp=000/0", Dout, Valid); end
        n_vec++; if (Overflow !== 1'b0 || Underflow !== 1'b0) begin n_err++; $display("FAIL midrst_err got=%b%b exp=00", Overflow, Underflow); end
        $display("async reset: Count=%0d Empty=%b Dout=%03h", Count, Empty, Dout);
        #1;
        RST = 1'b1;
        Din = 10'h055; WR_EN = 1'b1;
        step();
        n_vec++; if (Count !== 4'd1) begin n_err++; $display("FAIL postrst_count got=%0d exp=1", Count); end
        WR_EN = 1'b0; RD_EN = 1'b1;
        step();
        n_vec++; if (Dout !== 10'h055 || Valid !== 1'b1) begin n_err++; $display("FAIL postrst_read got=%h/%b exp=055/1", Dout, Valid); end
        n_vec++; if (Count !== 4'd0) begin n_err++; $display("FAIL postrst_empty got=%0d exp=0", Count); end
        $display("after reset: read Dout=%03h", Dout);
        RD_EN = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised synchronous FIFO for the memory lab: the next generation of the basic single-clock FIFO.
- Adds configurable width and depth, proper wrap-around pointers, an occupancy count, programmable almost-full and almost-empty flags, and overflow/underflow error pulses.
- Sits between a producer and a consumer in one clock domain. Always-driven output; no tri-state.

Parameters:
- DATA_WIDTH, 10, bits per word.
- ADDR_WIDTH, 8, pointer width; depth DEPTH = 2**ADDR_WIDTH.
- AF_LEVEL, 2**ADDR_WIDTH-2, Almost_Full asserted when Count >= AF_LEVEL.
- AE_LEVEL, 2, Almost_Empty asserted when Count <= AE_LEVEL.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- Din  input  DATA_WIDTH  write data.
- WR_EN  input  1  write request.
- RD_EN  input  1  read request.
- Dout  output  DATA_WIDTH  read data.
- Valid  output  1  Dout carries a word popped this cycle.
- Empty  output  1  Count == 0.
- Full  output  1  Count == DEPTH.
- Almost_Empty  output  1  Count <= AE_LEVEL.
- Almost_Full  output  1  Count >= AF_LEVEL.
- Count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- Overflow  output  1  one-cycle pulse on a rejected write.
- Underflow  output  1  one-cycle pulse on a rejected read.

Behaviour:
- Reset (RST=0, asynchronous):
  - wr_ptr, rd_ptr and Count go to 0.
  - Dout=0, Valid=0, Overflow=0, Underflow=0.
  - Empty=1, Full=0, Almost_Empty=1, Almost_Full=0 (AF_LEVEL>0).
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words; the first cycle after release behaves as an empty FIFO.
- Effective operations, evaluated on each rising CLK from the flags registered before the edge:
  - wr_ok = WR_EN & (!Full | RD_EN).
  - rd_ok = RD_EN & !Empty.
- Write: when wr_ok, MEM[wr_ptr] <= Din and wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- Read: when rd_ok, Dout <= MEM[rd_ptr], Valid <= 1 and rd_ptr increments modulo DEPTH. Otherwise Valid <= 0 and Dout holds its last value. Read latency is 1 cycle from the RD_EN edge.
- Count updates:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither.
- All flags are registered and derived from the next Count, so they are valid in the same cycle as Count.
- Simultaneous read and write:
  - When full, both succeed; Count stays DEPTH and Full stays 1.
  - When empty, the write succeeds and the read is rejected: Underflow pulses and Count becomes 1. No write-through bypass.
  - Otherwise both succeed and Count is unchanged.
- Overflow <= WR_EN & Full & !RD_EN. The write is dropped; pointers and memory are unchanged.
- Underflow <= RD_EN & Empty. The read is dropped; Dout holds and Valid=0.
- Error pulses last exactly one cycle per offending request and are not sticky.
- Data ordering is strictly first-in first-out across any number of pointer wraps.
- Parameter checks:
  - Elaboration fails if AF_LEVEL > DEPTH or AE_LEVEL >= DEPTH.
  - ADDR_WIDTH >= 1.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - Dout shows the head word combinationally from MEM[rd_ptr] whenever !Empty.
  - Valid = !Empty.
  - RD_EN acts as an acknowledge that advances rd_ptr at the clock edge.
  - The first written word appears on Dout the cycle after its write.
  - When empty, Dout holds the last shown value.
- Not defined: standard mode exactly as in Behaviour, with 1-cycle registered read latency.
- Count, flags and error pulses are identical in both modes.

Test Plan (DATA_WIDTH=10, ADDR_WIDTH=3, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
- Reset, then idle for 3 cycles -> Empty=1, Almost_Empty=1, Full=0, Count=0, Dout=0, Valid=0.
- Write 0x001..0x008 on consecutive cycles -> Almost_Empty falls after the 3rd write, Almost_Full rises after the 6th, Full=1 and Count=8 after the 8th. A 9th write of 0x3FF -> Overflow pulses for 1 cycle and Count stays 8.
- From full, read 8 times -> Dout=0x001..0x008 in order, each 1 cycle after RD_EN with Valid=1. Then Empty=1. A 9th read -> Underflow pulses, Valid=0, Dout stays 0x008.
- Wrap test: write 5, read 5, then write 6 words 0x100..0x105 -> pointers wrap past 7 and the reads return 0x100..0x105 in order.
- Simultaneous RD_EN+WR_EN: at Count=8 with Din=0x2AA -> Count stays 8, the oldest word pops, and 0x2AA is later read last. At Count=0 -> Underflow=1 and Count=1.
- Assert RST low mid-stream at Count=4 -> all outputs reach their reset values without a clock edge. After release, a write of 0x055 then a read returns 0x055.
